tone_sequencer: RTL and testbench
=================================

// Module: tone_sequencer
// PURPOSE
//  Upstream feeder for the buzzer pin BP1 on the 48 MHz board. Accepts one note request at a time
//  (pitch code + duration in ms) over a valid/ready handshake and plays it as a square wave on BP1.
//  After each note it inserts a fixed silent gap. A melody/UI controller drives it, note by note.
// PARAMETERS
//  CLK_HZ   48_000_000  input clock frequency; MS_CYC = CLK_HZ/1000 cycles per ms tick
//  GAP_MS   20          silent gap after each note, in ms; 0 = no gap state
// PORTS
//  CLK          in   1   system clock, rising edge
//  RST_N        in   1   asynchronous active-low reset
//  tone_valid   in   1   request present
//  tone_code    in   4   pitch code, see table
//  tone_dur_ms  in   12  note length in ms, 0..4095
//  tone_ready   out  1   high when a request can be accepted
//  stop         in   1   synchronous abort, level
//  busy         out  1   high in PLAY or GAP
//  done         out  1   one-cycle pulse when a note (incl. gap) completes normally
//  BP1          out  1   buzzer drive, registered
// BEHAVIOUR
//  Reset: state=IDLE, BP1=0, done=0, busy=0, all counters 0; tone_ready=1 after reset release.
//  States: IDLE -> PLAY -> GAP -> IDLE.
//   - GAP is skipped if GAP_MS=0.
//   - PLAY is skipped (direct to GAP) if tone_dur_ms=0.
//  tone_ready = (state==IDLE) && !stop, combinational.
//  Accept on the rising edge where tone_valid && tone_ready: code and duration are latched.
//   Later input changes are ignored until IDLE.
//  Half-period table HALF = CLK_HZ/(2*F), integer truncation. Values at 48 MHz:
//   1=C4  262 Hz  91603 | 2=D4 294 Hz 81632 | 3=E4 330 Hz 72727 | 4=F4 349 Hz 68767
//   5=G4  392 Hz  61224 | 6=A4 440 Hz 54545 | 7=B4 494 Hz 48582 | 8=C5 523 Hz 45889
//   9=1 kHz       24000 | 0,10..15 = rest (BP1 held 0 for the full duration)
//  PLAY entry: half-period counter=0, BP1=0.
//   - Counter counts 0..HALF-1.
//   - At HALF-1 it wraps to 0 and BP1 toggles. First rising edge of BP1 occurs HALF cycles after entry.
//  ms timer: counter 0..MS_CYC-1, cleared on every state entry.
//   - Wrap = 1 ms tick. The ms count is compared against the latched duration.
//   - PLAY lasts exactly dur*MS_CYC cycles. GAP lasts exactly GAP_MS*MS_CYC cycles.
//  BP1 is forced 0 on the first cycle outside PLAY, regardless of its phase.
//   - It is 0 in IDLE and GAP at all times.
//  done pulses for one cycle on the GAP->IDLE transition. If GAP is skipped, it pulses on PLAY->IDLE.
//  busy = (state!=IDLE), registered with the state.
//  stop=1 in PLAY or GAP: next edge goes to IDLE, BP1=0, counters cleared, no done pulse.
//  stop=1 in IDLE: holds ready low. Simultaneous valid+stop is not accepted.
//  Async reset mid-note: immediate BP1=0 and return to IDLE, with no glitch on release.
//  Width: all counters are 17 bits or wider. The ms count is 12 bits; no wrap is possible for dur<=4095.
// TESTING (CLK_HZ=48_000 -> MS_CYC=48, HALF(code 9)=24, GAP_MS=2 unless noted)
//  1. Reset, then code 9, dur 3 accepted at cycle 0.
//     -> BP1 period 48, first rise at cycle 25, PLAY=144 cycles, BP1=0 in GAP.
//     -> done pulse at cycle 1+144+96; ready high the next cycle.
//  2. Code 12 (rest), dur 2.
//     -> BP1 stays 0 throughout; busy high for 96+96 cycles; one done pulse.
//  3. Code 1, dur 0.
//     -> no BP1 activity; GAP of 96 cycles, then done.
//     -> with GAP_MS=0: done 1 cycle after accept.
//  4. stop asserted 50 cycles into PLAY of code 9.
//     -> IDLE next edge, BP1=0, no done.
//     -> valid held with stop: not accepted until stop drops.
//  5. Back-to-back: valid held high with new code each note.
//     -> accept exactly one per IDLE cycle; inputs changed mid-note have no effect.
//  6. RST_N pulsed low mid-PLAY while BP1=1.
//     -> BP1=0 asynchronously, state IDLE, ready=1 after release.

Source files
------------

// File: rtl/tone_sequencer.sv
// Note sequencer for buzzer pin BP1: takes one (pitch, duration) request at a time,
// plays it as a square wave, then inserts a fixed silent gap before accepting the next.
module tone_sequencer #(
    parameter int CLK_HZ = 48_000_000,
    parameter int GAP_MS = 20
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        tone_valid,
    input  logic [3:0]  tone_code,
    input  logic [11:0] tone_dur_ms,
    output logic        tone_ready,
    input  logic        stop,
    output logic        busy,
    output logic        done,
    output logic        BP1
);
    localparam int            CW       = 17;
    localparam int            MS_CYC   = CLK_HZ / 1000;
    localparam logic [CW-1:0] MS_LAST  = CW'(MS_CYC - 1);
    localparam logic [11:0]   GAP_LAST = 12'(GAP_MS - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] ZERO     = CW'(0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Half-period in clock cycles; zero marks a rest (no toggling).
    function automatic logic [CW-1:0] half_of(input logic [3:0] code);
        logic [CW-1:0] h;
        case (code)
            4'd1:    h = CW'(CLK_HZ / (2 * 262));
            4'd2:    h = CW'(CLK_HZ / (2 * 294));
            4'd3:    h = CW'(CLK_HZ / (2 * 330));
            4'd4:    h = CW'(CLK_HZ / (2 * 349));
            4'd5:    h = CW'(CLK_HZ / (2 * 392));
            4'd6:    h = CW'(CLK_HZ / (2 * 440));
            4'd7:    h = CW'(CLK_HZ / (2 * 494));
            4'd8:    h = CW'(CLK_HZ / (2 * 523));
            4'd9:    h = CW'(CLK_HZ / (2 * 1000));
            default: h = ZERO;
        endcase
        return h;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] half_q, half_d;
    logic [11:0]   dur_q, dur_d;
    logic [CW-1:0] half_cnt_q, half_cnt_d, half_run_s;
    logic [CW-1:0] ms_cyc_q, ms_cyc_d, ms_cyc_run_s;
    logic [11:0]   ms_cnt_q, ms_cnt_d, ms_cnt_run_s;
    logic          bp1_q, bp1_d, bp1_run_s;
    logic          done_q, done_d;
    logic          busy_q;
    logic          ready_s, accept_s, ms_wrap_s, keep_s;

    assign ready_s   = (state_q == S_IDLE) && !stop;
    assign accept_s  = tone_valid && ready_s;
    assign ms_wrap_s = (ms_cyc_q == MS_LAST);

    // Next-state, latched request and free-running counter values
    always_comb begin
        state_d      = state_q;
        half_d       = half_q;
        dur_d        = dur_q;
        done_d       = 1'b0;
        half_run_s   = half_cnt_q;
        bp1_run_s    = bp1_q;
        ms_cyc_run_s = ms_cyc_q;
        ms_cnt_run_s = ms_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    half_d = half_of(tone_code);
                    dur_d  = tone_dur_ms;
                    if (tone_dur_ms != 12'd0) begin
                        state_d = S_PLAY;
                    end else if (GAP_MS != 0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PLAY: begin
                if (half_q == ZERO) begin
                    half_run_s = ZERO;
                    bp1_run_s  = 1'b0;
                end else if (half_cnt_q == half_q - ONE) begin
                    half_run_s = ZERO;
                    bp1_run_s  = ~bp1_q;
                end else begin
                    half_run_s = half_cnt_q + ONE;
                    bp1_run_s  = bp1_q;
                end
                if (stop) begin
                    state_d = S_IDLE;
                end else if (ms_wrap_s && (ms_cnt_q == dur_q - 12'd1)) begin
                    if (GAP_MS != 0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (ms_wrap_s && (ms_cnt_q == GAP_LAST)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_GAP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (ms_wrap_s) begin
            ms_cyc_run_s = ZERO;
            ms_cnt_run_s = ms_cnt_q + 12'd1;
        end else begin
            ms_cyc_run_s = ms_cyc_q + ONE;
            ms_cnt_run_s = ms_cnt_q;
        end
    end

    // Counters only run while staying in PLAY/GAP; any state entry restarts them from zero.
    assign keep_s     = (state_d == state_q) && (state_q != S_IDLE);
    assign half_cnt_d = keep_s ? half_run_s : ZERO;
    assign ms_cyc_d   = keep_s ? ms_cyc_run_s : ZERO;
    assign ms_cnt_d   = keep_s ? ms_cnt_run_s : 12'd0;
    assign bp1_d      = (keep_s && (state_q == S_PLAY)) ? bp1_run_s : 1'b0;

    // State, counters and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            half_q     <= ZERO;
            dur_q      <= 12'd0;
            half_cnt_q <= ZERO;
            ms_cyc_q   <= ZERO;
            ms_cnt_q   <= 12'd0;
            bp1_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            dur_q      <= dur_d;
            half_cnt_q <= half_cnt_d;
            ms_cyc_q   <= ms_cyc_d;
            ms_cnt_q   <= ms_cnt_d;
            bp1_q      <= bp1_d;
            done_q     <= done_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign tone_ready = ready_s;
    assign busy       = busy_q;
    assign done       = done_q;
    assign BP1        = bp1_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer at CLK_HZ=48000: one instance with a 2 ms gap, one with no gap.
module tb_tone_sequencer;
    logic        CLK   = 1'b0;
    logic        RST_N = 1'b0;
    logic        valid = 1'b0;
    logic        sel   = 1'b0;
    logic        stop  = 1'b0;
    logic [3:0]  code  = 4'd0;
    logic [11:0] dur   = 12'd0;

    logic ready2, busy2, done2, bp2;
    logic ready0, busy0, done0, bp0;
    logic obs_ready, obs_busy, obs_done, obs_bp1;

    tone_sequencer #(.CLK_HZ(48_000), .GAP_MS(2)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .tone_valid(valid & ~sel), .tone_code(code),
        .tone_dur_ms(dur), .tone_ready(ready2), .stop(stop), .busy(busy2),
        .done(done2), .BP1(bp2)
    );
    tone_sequencer #(.CLK_HZ(48_000), .GAP_MS(0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .tone_valid(valid & sel), .tone_code(code),
        .tone_dur_ms(dur), .tone_ready(ready0), .stop(stop), .busy(busy0),
        .done(done0), .BP1(bp0)
    );

    assign obs_ready = sel ? ready0 : ready2;
    assign obs_busy  = sel ? busy0  : busy2;
    assign obs_done  = sel ? done0  : done2;
    assign obs_bp1   = sel ? bp0    : bp2;

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        g0;
        logic [3:0]  code;
        logic [11:0] dur;
        int          busy_cyc;
        int          rises;
        int          first_rise;
        int          done_at;
    } vec_t;

    typedef struct {
        int busy_cyc;
        int rises;
        int first_rise;
        int done_at;
    } exp_t;

    exp_t exp_q[$];
    int   done_exp_q[$];
    vec_t tbl[12];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Plays one note from the table, measuring cycles relative to the accept edge (cycle 0).
    task automatic run_note(input vec_t v);
        exp_t e;
        exp_t m;
        int   waited;
        int   bp1_gap;
        bit   got_done;
        logic prev;
        sel = v.g0;
        @(negedge CLK);
        code  = v.code;
        dur   = v.dur;
        valid = 1'b1;
        waited = 0;
        while (!obs_ready && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        check("ready_before_accept", int'(obs_ready), 1);
        e.busy_cyc = v.busy_cyc;  e.rises = v.rises;
        e.first_rise = v.first_rise;  e.done_at = v.done_at;
        exp_q.push_back(e);
        @(posedge CLK);
        m.busy_cyc = 0;  m.rises = 0;  m.first_rise = 0;  m.done_at = -1;
        prev = 1'b0;  bp1_gap = 0;  got_done = 1'b0;
        for (int c = 1; c <= 6000 && !got_done; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                valid = 1'b0;
                code  = ~v.code;
                dur   = v.dur + 12'd7;
            end
            if (obs_busy) m.busy_cyc++;
            if (obs_bp1 && !prev) begin
                m.rises++;
                if (m.first_rise == 0) m.first_rise = c;
            end
            if (obs_bp1 && (c > int'(v.dur) * 48)) bp1_gap++;
            prev = obs_bp1;
            if (obs_done) begin
                got_done  = 1'b1;
                m.done_at = c;
                check("ready_at_done", int'(obs_ready), 1);
            end
        end
        e = exp_q.pop_front();
        check("busy_cycles", m.busy_cyc, e.busy_cyc);
        check("bp1_rises", m.rises, e.rises);
        check("first_rise", m.first_rise, e.first_rise);
        check("done_cycle", m.done_at, e.done_at);
        check("bp1_outside_play", bp1_gap, 0);
        @(negedge CLK);
        check("done_single_pulse", int'(obs_done), 0);
    endtask

    // Stop during PLAY of code 9, then valid held with stop, then a clean abort.
    task automatic run_stop(input int at, input int exp_bp);
        int done_seen;
        done_seen = 0;
        sel = 1'b0;
        @(negedge CLK);
        code = 4'd9;  dur = 12'd3;  valid = 1'b1;
        @(posedge CLK);
        for (int c = 1; c <= at; c++) begin
            @(negedge CLK);
            if (c == 1) valid = 1'b0;
            done_seen += int'(obs_done);
        end
        check("stop_pre_bp1", int'(obs_bp1), exp_bp);
        stop  = 1'b1;
        valid = 1'b1;
        @(negedge CLK);
        check("stop_busy", int'(obs_busy), 0);
        check("stop_bp1", int'(obs_bp1), 0);
        check("stop_ready", int'(obs_ready), 0);
        repeat (4) begin
            @(negedge CLK);
            done_seen += int'(obs_done);
        end
        check("stop_valid_not_accepted", int'(obs_busy), 0);
        stop = 1'b0;
        #1;
        check("ready_after_stop_drop", int'(obs_ready), 1);
        @(negedge CLK);
        done_seen += int'(obs_done);
        check("accept_after_stop_drop", int'(obs_busy), 1);
        valid = 1'b0;
        stop  = 1'b1;
        @(negedge CLK);
        check("stop_gap_or_play_abort", int'(obs_busy), 0);
        stop = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            done_seen += int'(obs_done);
        end
        check("stop_no_done", done_seen, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dones[$];
        int   r1, r2, exp_done, got;
        logic b145, b146, prev;

        tbl[0]  = '{1'b0, 4'd9,  12'd3, 240, 3, 25, 241};
        tbl[1]  = '{1'b0, 4'd12, 12'd2, 192, 0, 0,  193};
        tbl[2]  = '{1'b0, 4'd1,  12'd0, 96,  0, 0,  97};
        tbl[3]  = '{1'b0, 4'd9,  12'd1, 144, 1, 25, 145};
        tbl[4]  = '{1'b0, 4'd8,  12'd2, 192, 1, 46, 193};
        tbl[5]  = '{1'b0, 4'd6,  12'd1, 144, 0, 0,  145};
        tbl[6]  = '{1'b0, 4'd0,  12'd1, 144, 0, 0,  145};
        tbl[7]  = '{1'b0, 4'd15, 12'd1, 144, 0, 0,  145};
        tbl[8]  = '{1'b1, 4'd1,  12'd0, 0,   0, 0,  1};
        tbl[9]  = '{1'b1, 4'd9,  12'd1, 48,  1, 25, 49};
        tbl[10] = '{1'b0, 4'd2,  12'd3, 240, 1, 82, 241};
        tbl[11] = '{1'b0, 4'd7,  12'd2, 192, 1, 49, 193};

        #1;
        check("reset_bp1", int'(bp2), 0);
        check("reset_busy", int'(busy2), 0);
        check("reset_done", int'(done2), 0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("ready_after_reset", int'(ready2), 1);
        check("ready_after_reset_nogap", int'(ready0), 1);

        for (int i = 0; i < 12; i++) run_note(tbl[i]);

        // Back-to-back with valid held high; inputs change during each note.
        sel = 1'b0;
        @(negedge CLK);
        code = 4'd9;  dur = 12'd1;  valid = 1'b1;
        check("b2b_ready", int'(obs_ready), 1);
        done_exp_q.push_back(145);
        done_exp_q.push_back(338);
        @(posedge CLK);
        r1 = 0;  r2 = 0;  prev = 1'b0;  b145 = 1'b1;  b146 = 1'b0;
        for (int c = 1; c <= 360; c++) begin
            @(negedge CLK);
            if (c == 1)   begin code = 4'd12; dur = 12'd2; end
            if (c == 200) begin code = 4'd9;  dur = 12'd3; end
            if (c == 300) valid = 1'b0;
            if (obs_done) dones.push_back(c);
            if (obs_bp1 && !prev) begin
                if (c <= 145) r1++;
                else r2++;
            end
            prev = obs_bp1;
            if (c == 145) b145 = obs_busy;
            if (c == 146) b146 = obs_busy;
        end
        check("b2b_done_count", dones.size(), 2);
        while (done_exp_q.size() > 0) begin
            exp_done = done_exp_q.pop_front();
            got = (dones.size() > 0) ? dones.pop_front() : -1;
            check("b2b_done_cycle", got, exp_done);
        end
        check("b2b_first_note_rises", r1, 1);
        check("b2b_second_note_rest", r2, 0);
        check("b2b_idle_cycle", int'(b145), 0);
        check("b2b_reaccept", int'(b146), 1);

        run_stop(50, 0);
        run_stop(80, 1);

        // Asynchronous reset while BP1 is high.
        sel = 1'b0;
        @(negedge CLK);
        code = 4'd9;  dur = 12'd3;  valid = 1'b1;
        @(posedge CLK);
        for (int c = 1; c <= 30; c++) begin
            @(negedge CLK);
            if (c == 1) valid = 1'b0;
        end
        check("rst_pre_bp1", int'(bp2), 1);
        #2 RST_N = 1'b0;
        #1;
        check("rst_async_bp1", int'(bp2), 0);
        check("rst_async_busy", int'(busy2), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("rst_release_ready", int'(ready2), 1);
        check("rst_release_bp1", int'(bp2), 0);
        run_note(tbl[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
